// File: rtl/parity_tx_pkg.sv
// Shared types and helpers for the parity serial transmitter and its future receiver.
package parity_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Cycles from the first start-bit cycle through the done cycle.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit);
    return (data_w + 3) * clks_per_bit;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..N-1 while enabled and ticks on the last cycle of each bit.
module bit_timer #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start bit, data LSB first, parity bit, stop bit.
module parity_serial_tx
  import parity_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] shift, shift_next;
  logic [IW-1:0]     idx, idx_next;
  logic              par, par_next;
  logic              tx_q, tx_next;
  logic              tick;
  logic              accept;

  assign ready  = (state == IDLE);
  assign busy   = (state != IDLE);
  assign accept = valid && ready;
  assign done   = (state == STOP) && tick;
  assign tx     = tx_q;

  bit_timer #(.N(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (busy),
    .tick  (tick)
  );

  always_comb begin
    state_next = state;
    shift_next = shift;
    idx_next   = idx;
    par_next   = par;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shift_next = data_in;
          idx_next   = '0;
          par_next   = PARITY_ODD ? ~^data_in : ^data_in;
        end
      end
      START:  if (tick) state_next = DATA;
      DATA: begin
        if (tick) begin
          shift_next = shift >> 1;
          if (idx == LAST_IDX) state_next = PARITY;
          else                 idx_next   = idx + 1'b1;
        end
      end
      PARITY: if (tick) state_next = STOP;
      STOP:   if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // tx is registered from the upcoming state so the line never glitches.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      par   <= 1'b0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_next;
      shift <= shift_next;
      idx   <= idx_next;
      par   <= par_next;
      tx_q  <= tx_next;
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Randomised self-checking bench for parity_serial_tx across three parameter sets.
module tb_parity_serial_tx;
  import parity_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic [3:0] data_c;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int checks   = 0;
  int failures = 0;
  int dw[3]    = '{8, 8, 4};
  int cpb[3]   = '{4, 4, 1};
  int odd[3]   = '{0, 1, 0};
  logic exp_bits[$];

  always #5 clk = ~clk;

  parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .valid(valid_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));

  parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .valid(valid_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_c (
    .clk(clk), .rst(rst), .data_in(data_c), .valid(valid_c),
    .ready(ready_c), .tx(tx_c), .busy(busy_c), .done(done_c));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic getTx(input int sel);
    case (sel) 0: return tx_a; 1: return tx_b; default: return tx_c; endcase
  endfunction
  function automatic logic getReady(input int sel);
    case (sel) 0: return ready_a; 1: return ready_b; default: return ready_c; endcase
  endfunction
  function automatic logic getBusy(input int sel);
    case (sel) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction
  function automatic logic getDone(input int sel);
    case (sel) 0: return done_a; 1: return done_b; default: return done_c; endcase
  endfunction

  task automatic applyStimulus(input int sel, input logic [15:0] word, input logic v);
    case (sel)
      0:       begin data_a = word[7:0]; valid_a = v; end
      1:       begin data_b = word[7:0]; valid_b = v; end
      default: begin data_c = word[3:0]; valid_c = v; end
    endcase
  endtask

  task automatic checkIdle(input int sel, input string tag);
    checkOutput({tag, "_tx"},    getTx(sel),    1'b1);
    checkOutput({tag, "_ready"}, getReady(sel), 1'b1);
    checkOutput({tag, "_busy"},  getBusy(sel),  1'b0);
    checkOutput({tag, "_done"},  getDone(sel),  1'b0);
  endtask

  // Reference frame: start, data LSB first, parity making the ones count even/odd, stop.
  task automatic buildFrame(input int sel, input logic [15:0] word);
    int ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < dw[sel]; i++) begin
      exp_bits.push_back(word[i]);
      ones += int'(word[i]);
    end
    exp_bits.push_back(((ones % 2) == 1) ^ (odd[sel] == 1));
    exp_bits.push_back(1'b1);
  endtask

  // Sends one word and checks every line cycle; abort_at >= 0 resets at that frame cycle.
  task automatic runFrame(input int sel, input logic [15:0] word, input bit keep, input int abort_at);
    int waited = 0;
    int len;
    buildFrame(sel, word);
    len = frame_cycles(dw[sel], cpb[sel]);
    applyStimulus(sel, word, 1'b1);
    while (!getReady(sel) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_wait", 32'(waited < 500), 32'd1);
    @(negedge clk);
    for (int cyc = 0; cyc < len; cyc++) begin
      if (cyc > 0) @(negedge clk);
      checkOutput("frame_tx",    getTx(sel),    exp_bits[cyc / cpb[sel]]);
      checkOutput("frame_done",  getDone(sel),  1'(cyc == len - 1));
      checkOutput("frame_busy",  getBusy(sel),  1'b1);
      checkOutput("frame_ready", getReady(sel), 1'b0);
      applyStimulus(sel, 16'($urandom), keep);
      if (cyc == abort_at) begin
        rst = 1'b1;
        applyStimulus(sel, 16'($urandom), 1'b0);
        @(negedge clk);
        checkIdle(sel, "abort");
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          checkOutput("abort_no_done", getDone(sel), 1'b0);
          checkOutput("abort_tx_idle", getTx(sel),   1'b1);
        end
        return;
      end
    end
    @(negedge clk);
    checkIdle(sel, "gap");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sel;
    int n;
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) checkIdle(s, "reset");
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) checkIdle(s, "post_reset");

    runFrame(0, 16'hA5, 1'b0, -1);
    runFrame(1, 16'hA5, 1'b0, -1);
    runFrame(0, 16'h07, 1'b0, -1);
    runFrame(0, 16'h00, 1'b1, -1);
    runFrame(0, 16'hFF, 1'b0, -1);
    runFrame(0, 16'h3C, 1'b0, 4 + 3 * 4 + 1);
    runFrame(0, 16'h81, 1'b0, -1);
    runFrame(2, 16'h000B, 1'b0, -1);

    repeat (12) begin
      sel = $urandom_range(0, 2);
      n   = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) runFrame(sel, 16'($urandom), j < n - 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
- Serial frame transmitter that emits the parity bit a downstream XNOR-based parity/equality checker validates.
- Accepts one parallel word per valid/ready handshake and serializes it as: start bit, data bits LSB first, one parity bit, stop bit.
- Sits between a parallel producer and a single-wire serial link. The receiving end uses XNOR-style comparison to check integrity.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx (>=1)
- PARITY_ODD, 0, 0 = even parity (XOR reduction), 1 = odd parity (XNOR reduction)

Ports:
- clk  input  1  single system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  DATA_W  word to transmit; sampled only on handshake
- valid  input  1  producer has a word on data_in
- ready  output  1  block can accept a word this cycle
- tx  output  1  serial line; idles high
- busy  output  1  frame in progress (any state other than IDLE)
- done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state=IDLE, tx=1, ready=1, busy=0, done=0. The shift register, bit index and timer are cleared.
- Reset mid-frame: on the next edge tx=1 and state=IDLE. The frame is discarded, no done pulse is produced, and the latched word is lost.
- Handshake:
  - ready = (state==IDLE), registered-state decode.
  - Transfer occurs on a clk edge where valid && ready.
  - data_in is latched into the shift register on that edge. Parity is computed on the same edge and latched.
  - valid with ready=0 is ignored. The producer holds valid until accepted.
- Parity:
  - p = ^data_in when PARITY_ODD=0.
  - p = ~^data_in when PARITY_ODD=1.
  - Result: total ones across data+parity is even (PARITY_ODD=0) or odd (PARITY_ODD=1).
- FSM states, each lasting CLKS_PER_BIT cycles per bit:
  - IDLE: tx=1. On handshake go to START.
  - START: tx=0, then go to DATA.
  - DATA: tx=shift[0]. At the end of each bit period, shift right and increment the bit index. After DATA_W bits go to PARITY.
  - PARITY: tx=p, then go to STOP.
  - STOP: tx=1. done=1 on the last cycle of STOP, then go to IDLE.
- Latency: tx falls on the first cycle after the handshake edge.
- Frame length: (DATA_W+3)*CLKS_PER_BIT cycles, counted from the first start-bit cycle through the done cycle.
- Back-to-back: ready reasserts the cycle after done. A held valid is accepted on that cycle, so the IDLE gap is exactly 1 cycle (tx=1).
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Asserts bit_end when count==CLKS_PER_BIT-1.
  - Reset to 0 on handshake and on rst.
  - With CLKS_PER_BIT=1, bit_end is constantly high in non-IDLE states.
- tx is driven from a register, so there are no combinational glitches.
- data_in changes during a frame have no effect.

Decomposition:
- Package parity_tx_pkg containing:
  - enum state_t {IDLE, START, DATA, PARITY, STOP}
  - function frame_cycles(DATA_W, CLKS_PER_BIT) for the bench
- Sub-module bit_timer:
  - Parameter N.
  - Ports clk, rst, clear, en, tick.
  - Reused later by the matching receiver.

Test Plan:
1. rst held 3 cycles mid-idle, then released -> tx=1, ready=1, busy=0, done=0 every cycle.
2. DATA_W=8, CLKS_PER_BIT=4, PARITY_ODD=0, send 8'hA5 -> line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles (parity=0). done fires 44 cycles after the first start cycle.
3. Same word 8'hA5 with PARITY_ODD=1 -> parity bit=1. Send 8'h07 with PARITY_ODD=0 -> parity bit=1.
4. valid held high with words 8'h00 then 8'hFF -> second word accepted the cycle after done. Exactly one idle-high cycle appears between frames. Parity bits are 0 and 0 (even).
5. Assert rst during DATA bit 3 of 8'h3C -> tx=1 and state IDLE on the next edge, no done pulse. A following 8'h81 frame is correct.
6. CLKS_PER_BIT=1, DATA_W=4, send 4'b1011 -> tx sequence 0,1,1,0,1,1,1 on consecutive cycles (parity=1). done on the 7th cycle.
